fetch_queue: RTL and testbench

Instruction fetch queue for the dual-issue pipeline. Requests two 32-bit instruction words per cycle from instruction memory, buffers them in a circular queue, and presents the two oldest words to the issue stage. The issue stage returns how many of the two it issued (0, 1 or 2), and the queue retires exactly that many. Redirects from branch/jump resolution flush the queue and restart fetch at a new PC.

---
 rtl/fetch_pkg.sv | 15 +
 rtl/fetch_queue_mem.sv | 36 +++
 rtl/fetch_queue.sv | 142 ++++++++++++++
 tb/tb_fetch_queue.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared constants and types for the dual-issue instruction fetch queue.
package fetch_pkg;

  localparam int          DEFAULT_DEPTH = 8;
  localparam logic [31:0] BUBBLE_WORD   = 32'h0000_0000;
  localparam logic [31:0] NOP_WORD      = 32'h0000_0013;

  typedef logic [1:0] issue_cnt_t;

  // The issue stage never retires more than two words; an illegal 3 retires two.
  function automatic issue_cnt_t sat_consume(input issue_cnt_t c);
    return (c == 2'd3) ? 2'd2 : c;
  endfunction

endpackage

// File: rtl/fetch_queue_mem.sv
// DEPTH x 32 queue storage: two write ports at wr_ptr/wr_ptr+1, two read ports at rd_ptr/rd_ptr+1.
module fetch_queue_mem
  import fetch_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH
) (
  input  logic                     clk,
  input  logic                     wr_en,
  input  logic [$clog2(DEPTH)-1:0] wr_ptr,
  input  logic [63:0]              wr_data,
  input  logic [$clog2(DEPTH)-1:0] rd_ptr,
  output logic [31:0]              rd_data0,
  output logic [31:0]              rd_data1
);

  localparam int PW = $clog2(DEPTH);

  logic [31:0]   mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_hi;
  logic [PW-1:0] rd_ptr_hi;

  assign wr_ptr_hi = wr_ptr + PW'(1);
  assign rd_ptr_hi = rd_ptr + PW'(1);

  // Storage is never read while its slot is invalid, so it carries no reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_ptr]    <= wr_data[31:0];
      mem_q[wr_ptr_hi] <= wr_data[63:32];
    end
  end

  assign rd_data0 = mem_q[rd_ptr];
  assign rd_data1 = mem_q[rd_ptr_hi];

endmodule

// File: rtl/fetch_queue.sv
// Dual-issue instruction fetch queue: fetches 8 bytes per request, presents the two oldest words.
// Optional FETCH_QUEUE_STALL_CNT_EN adds a saturating stallCycles counter output.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int          DEPTH    = DEFAULT_DEPTH,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     redirectValid,
  input  logic [31:0]              redirectPc,
  output logic                     imemReq,
  output logic [31:0]              imemAddr,
  input  logic [63:0]              imemRdata,
  input  issue_cnt_t               consume,
  output logic [31:0]              inst1,
  output logic [31:0]              inst2,
  output logic [31:0]              pc1,
  output logic [$clog2(DEPTH):0]   count
`ifdef FETCH_QUEUE_STALL_CNT_EN
  ,
  output logic [31:0]              stallCycles
`endif
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW:0] ROOM_LIMIT = (CW+1)'(DEPTH - 2);

  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;
  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [31:0]   head_pc_q, head_pc_d;
  logic          pending_q, pending_d;

  issue_cnt_t    cons_sat;
  logic [CW-1:0] eff_cnt;
  logic [CW-1:0] push_cnt;
  logic [CW:0]   occupied;
  logic          push;
  logic          req;
  logic [31:0]   rd_word0;
  logic [31:0]   rd_word1;

  always_comb begin
    cons_sat = sat_consume(consume);
    eff_cnt  = (CW'(cons_sat) > count_q) ? count_q : CW'(cons_sat);
    push     = pending_q && !redirectValid;
    push_cnt = push ? CW'(2) : '0;
    // In-flight words already own their slots, so they count against free space.
    occupied = {1'b0, count_q} + (pending_q ? (CW+1)'(2) : '0);
    req      = !rst && !redirectValid && (occupied <= ROOM_LIMIT);

    head_d     = head_q;
    tail_d     = tail_q;
    count_d    = count_q;
    fetch_pc_d = fetch_pc_q;
    head_pc_d  = head_pc_q;
    pending_d  = pending_q;

    if (redirectValid) begin
      head_d     = '0;
      tail_d     = '0;
      count_d    = '0;
      fetch_pc_d = redirectPc;
      head_pc_d  = redirectPc;
      pending_d  = 1'b0;
    end else begin
      if (push) begin
        tail_d = tail_q + PW'(2);
      end
      head_d    = head_q + eff_cnt[PW-1:0];
      head_pc_d = head_pc_q + (32'(eff_cnt) << 2);
      count_d   = count_q + push_cnt - eff_cnt;
      pending_d = req;
      if (req) begin
        fetch_pc_d = fetch_pc_q + 32'd8;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      fetch_pc_q <= RESET_PC;
      head_pc_q  <= RESET_PC;
      pending_q  <= 1'b0;
    end else begin
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      fetch_pc_q <= fetch_pc_d;
      head_pc_q  <= head_pc_d;
      pending_q  <= pending_d;
    end
  end

  fetch_queue_mem #(
    .DEPTH (DEPTH)
  ) u_mem (
    .clk      (clk),
    .wr_en    (push),
    .wr_ptr   (tail_q),
    .wr_data  (imemRdata),
    .rd_ptr   (head_q),
    .rd_data0 (rd_word0),
    .rd_data1 (rd_word1)
  );

  assign imemReq  = req;
  assign imemAddr = fetch_pc_q;
  assign inst1    = (count_q != '0)       ? rd_word0 : BUBBLE_WORD;
  assign inst2    = (count_q >= CW'(2))   ? rd_word1 : BUBBLE_WORD;
  assign pc1      = head_pc_q;
  assign count    = count_q;

`ifdef FETCH_QUEUE_STALL_CNT_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if ((count_q < CW'(2)) && !redirectValid && (stall_cnt_q != 32'hFFFF_FFFF)) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stallCycles = stall_cnt_q;
`endif

endmodule

// File: tb/tb_fetch_queue.sv
// Scoreboard bench for fetch_queue: directed per-cycle expectations, memory returns word = address.
module tb_fetch_queue;

  localparam int F_REQ   = 0;
  localparam int F_ADDR  = 1;
  localparam int F_INST1 = 2;
  localparam int F_INST2 = 3;
  localparam int F_PC1   = 4;
  localparam int F_COUNT = 5;

  logic        clk;
  logic        rst;
  logic        redirectValid;
  logic [31:0] redirectPc;
  logic        imemReq;
  logic [31:0] imemAddr;
  logic [63:0] imemRdata;
  logic [1:0]  consume;
  logic [31:0] inst1;
  logic [31:0] inst2;
  logic [31:0] pc1;
  logic [3:0]  count;
`ifdef FETCH_QUEUE_STALL_CNT_EN
  logic [31:0] stallCycles;
`endif

  fetch_queue #(
    .DEPTH    (8),
    .RESET_PC (32'h0000_0000)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .redirectValid (redirectValid),
    .redirectPc    (redirectPc),
    .imemReq       (imemReq),
    .imemAddr      (imemAddr),
    .imemRdata     (imemRdata),
    .consume       (consume),
    .inst1         (inst1),
    .inst2         (inst2),
    .pc1           (pc1),
    .count         (count)
`ifdef FETCH_QUEUE_STALL_CNT_EN
    ,
    .stallCycles   (stallCycles)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          cyc;
    string       nm;
    int          fld;
    logic [31:0] val;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        cur_e;
  logic [31:0] act;
  int          cyc;
  int          n_vec;
  int          n_err;
  logic        last_req;
  logic [31:0] last_addr;

  task automatic ex(input int c, input string nm, input int f, input logic [31:0] v);
    exp_t e;
    int   idx;
    e.cyc = c;
    e.nm  = nm;
    e.fld = f;
    e.val = v;
    idx   = exp_q.size();
    for (int i = 0; i < exp_q.size(); i++) begin
      if (exp_q[i].cyc > c) begin
        idx = i;
        break;
      end
    end
    exp_q.insert(idx, e);
  endtask

  task automatic ex_state(input int c, input string tag, input logic [31:0] i1,
                          input logic [31:0] i2, input logic [31:0] p, input logic [31:0] cnt);
    ex(c, {tag, ".inst1"}, F_INST1, i1);
    ex(c, {tag, ".inst2"}, F_INST2, i2);
    ex(c, {tag, ".pc1"},   F_PC1,   p);
    ex(c, {tag, ".count"}, F_COUNT, cnt);
  endtask

  task automatic ex_req(input int c, input string tag, input logic r, input logic [31:0] a);
    ex(c, {tag, ".imemReq"}, F_REQ, {31'b0, r});
    if (r) ex(c, {tag, ".imemAddr"}, F_ADDR, a);
  endtask

  function automatic logic [31:0] field_value(input int f);
    case (f)
      F_REQ:   return {31'b0, imemReq};
      F_ADDR:  return imemAddr;
      F_INST1: return inst1;
      F_INST2: return inst2;
      F_PC1:   return pc1;
      F_COUNT: return 32'(count);
      default: return 32'hxxxx_xxxx;
    endcase
  endfunction

  // One clock cycle of stimulus; the memory model answers last cycle's request with word = address.
  task automatic tick(input logic r, input logic rv, input logic [31:0] rp, input logic [1:0] c);
    @(negedge clk);
    rst           = r;
    cyc           = cyc + 1;
    imemRdata     = last_req ? {last_addr + 32'd4, last_addr} : 64'hBAD0_BAD1_BAD2_BAD3;
    redirectValid = rv;
    redirectPc    = rp;
    consume       = c;
    #1;
    last_req  = imemReq;
    last_addr = imemAddr;
  endtask

  // Monitor: pops every expectation due this cycle and compares it with the live outputs.
  always @(negedge clk) begin
    #1;
    while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
      cur_e = exp_q.pop_front();
      act   = field_value(cur_e.fld);
      n_vec = n_vec + 1;
      if (cur_e.cyc != cyc || act !== cur_e.val) begin
        n_err = n_err + 1;
        $display("FAIL %s cycle %0d: got %h, expected %h (due cycle %0d)",
                 cur_e.nm, cyc, act, cur_e.val, cur_e.cyc);
      end
    end
  end

  initial begin
    logic [31:0] p;
    rst           = 1'b1;
    redirectValid = 1'b0;
    redirectPc    = '0;
    consume       = '0;
    imemRdata     = '0;
    cyc           = 0;
    n_vec         = 0;
    n_err         = 0;
    last_req      = 1'b0;
    last_addr     = '0;

    // Reset state, then boot fill with consume=0 until the queue is full.
    ex_state(2, "reset", 32'h0, 32'h0, 32'h0, 0);
    ex_req(2, "reset", 1'b0, 32'h0);
    ex_req(3, "boot", 1'b1, 32'h0);
    ex_req(4, "boot", 1'b1, 32'h8);
    ex_state(5, "boot", 32'h0, 32'h4, 32'h0, 2);
    ex_req(5, "boot", 1'b1, 32'h10);
    ex(6, "fill.count", F_COUNT, 32'd4);
    ex_req(6, "fill", 1'b1, 32'h18);
    ex(7, "fill.count", F_COUNT, 32'd6);
    ex_req(7, "fill", 1'b0, 32'h0);
    ex(8, "full.count", F_COUNT, 32'd8);
    ex_req(8, "full", 1'b0, 32'h0);
    ex_state(9, "full", 32'h0, 32'h4, 32'h0, 8);
    ex_req(9, "full", 1'b0, 32'h0);
    ex_state(10, "drain", 32'h8, 32'hC, 32'h8, 6);
    ex_req(10, "drain", 1'b1, 32'h20);
    // Redirect while the 0x20 response lands: it must be dropped.
    ex(11, "redir.count", F_COUNT, 32'd6);
    ex(11, "redir.inst1", F_INST1, 32'h8);
    ex_req(11, "redir", 1'b0, 32'h0);
    ex_state(12, "flush", 32'h0, 32'h0, 32'h104, 0);
    ex_req(12, "flush", 1'b1, 32'h104);
    ex_state(13, "clamp", 32'h0, 32'h0, 32'h104, 0);
    ex_req(13, "clamp", 1'b1, 32'h10C);
    ex_state(14, "refill", 32'h104, 32'h108, 32'h104, 2);
    ex_req(14, "refill", 1'b1, 32'h114);
    ex_state(15, "cons3", 32'h10C, 32'h110, 32'h10C, 2);
    ex_req(15, "cons3", 1'b1, 32'h11C);
    for (int k = 0; k < 10; k++) begin
      ex(15 + k, "c1.pc1",   F_PC1,   32'h10C + 32'(4 * k));
      ex(15 + k, "c1.inst1", F_INST1, 32'h10C + 32'(4 * k));
    end
    // Asynchronous reset mid-stream, then release with a stale response discarded.
    ex_state(25, "arst", 32'h0, 32'h0, 32'h0, 0);
    ex_req(25, "arst", 1'b0, 32'h0);
    ex(26, "rel.count", F_COUNT, 32'd0);
    ex_req(26, "rel", 1'b1, 32'h0);
    ex(27, "rel.count", F_COUNT, 32'd0);
    ex_req(27, "rel", 1'b1, 32'h8);
    ex_state(28, "rel", 32'h0, 32'h4, 32'h0, 2);
    ex_req(28, "wredir", 1'b0, 32'h0);
    // Redirect near the top of the address space, then consume=2 through pointer and PC wrap.
    ex_state(29, "wflush", 32'h0, 32'h0, 32'hFFFF_FFF0, 0);
    ex_req(29, "wflush", 1'b1, 32'hFFFF_FFF0);
    ex(30, "wfill.count", F_COUNT, 32'd0);
    ex_req(30, "wfill", 1'b1, 32'hFFFF_FFF8);
    for (int k = 0; k < 8; k++) begin
      p = 32'hFFFF_FFF0 + 32'(8 * k);
      ex_state(31 + k, "wrap", p, p + 32'd4, p, 2);
      ex_req(31 + k, "wrap", 1'b1, 32'(8 * k));
    end

    tick(1'b1, 1'b0, 32'h0, 2'd0);
    tick(1'b1, 1'b0, 32'h0, 2'd0);
    for (int i = 3; i <= 8; i++) tick(1'b0, 1'b0, 32'h0, 2'd0);
    tick(1'b0, 1'b0, 32'h0, 2'd2);
    tick(1'b0, 1'b0, 32'h0, 2'd0);
    tick(1'b0, 1'b1, 32'h104, 2'd0);
    tick(1'b0, 1'b0, 32'h0, 2'd2);
    tick(1'b0, 1'b0, 32'h0, 2'd2);
    tick(1'b0, 1'b0, 32'h0, 2'd3);
    for (int i = 15; i <= 24; i++) tick(1'b0, 1'b0, 32'h0, 2'd1);
    tick(1'b1, 1'b0, 32'h0, 2'd0);
    tick(1'b0, 1'b0, 32'h0, 2'd0);
    tick(1'b0, 1'b0, 32'h0, 2'd0);
    tick(1'b0, 1'b1, 32'hFFFF_FFF0, 2'd0);
    tick(1'b0, 1'b0, 32'h0, 2'd0);
    tick(1'b0, 1'b0, 32'h0, 2'd0);
    for (int i = 31; i <= 38; i++) tick(1'b0, 1'b0, 32'h0, 2'd2);
    tick(1'b0, 1'b0, 32'h0, 2'd0);

    @(negedge clk);
    #2;
    if (exp_q.size() != 0) begin
      $display("FAIL unchecked_expectations: %0d left, expected 0", exp_q.size());
      n_err = n_err + exp_q.size();
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
